// File: rtl/shift_receiver_if.sv
// shift_receiver_if: groups the control, serial and result signals of one shift_receiver.
//
// Signal names carry the receiver's point of view:
//   i_start      frame request, honoured only while the receiver is idle
//   i_serial_in  serial data bit, LSB first
//   i_bit_valid  i_serial_in is sampled on a clock edge where this is high
//   i_abort      drop the frame in progress
//   o_data_out   last completed frame, held until the next completion
//   o_data_valid one-cycle pulse, high in the cycle o_data_out carries a new frame
//   o_parity_err parity mismatch, qualified by o_data_valid
//   o_busy       receiver is not idle
//   o_bit_count  data bits captured so far in the current frame
//
// Modports:
//   master - the side that produces the serial stream (bench or upstream logic)
//   slave  - the receiver itself
interface shift_receiver_if #(
  parameter int unsigned WIDTH = 8
) ();

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic             i_start;
  logic             i_serial_in;
  logic             i_bit_valid;
  logic             i_abort;
  logic [WIDTH-1:0] o_data_out;
  logic             o_data_valid;
  logic             o_parity_err;
  logic             o_busy;
  logic [CntW-1:0]  o_bit_count;

  modport master (
    output i_start,
    output i_serial_in,
    output i_bit_valid,
    output i_abort,
    input  o_data_out,
    input  o_data_valid,
    input  o_parity_err,
    input  o_busy,
    input  o_bit_count
  );

  modport slave (
    input  i_start,
    input  i_serial_in,
    input  i_bit_valid,
    input  i_abort,
    output o_data_out,
    output o_data_valid,
    output o_parity_err,
    output o_busy,
    output o_bit_count
  );

endinterface

// File: rtl/shift_receiver.sv
// shift_receiver: collects a WIDTH-bit frame sent LSB first over a serial line, with an
// optional trailing even-parity bit, and presents the completed word with a one-cycle
// valid pulse.
//
// Ports:
//   i_clk    sole clock, all state changes on its rising edge
//   i_reset  synchronous active-high reset, overrides every other input
//   bus      shift_receiver_if.slave: start/serial_in/bit_valid/abort in,
//            data_out/data_valid/parity_err/busy/bit_count out
//
// Parameters:
//   WIDTH      data bits per frame (2..16); must match the interface WIDTH
//   PARITY_EN  1 = one even-parity bit follows the data bits
module shift_receiver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input logic             i_clk,
  input logic             i_reset,
  shift_receiver_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StPar,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [CntW-1:0]  r_bit_count;
  logic [CntW-1:0]  w_bit_count_next;
  logic             r_parity_err;
  logic             w_parity_err_next;
  logic [WIDTH-1:0] r_data_out;
  logic             w_load_out;

  // State register and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_shreg      <= '0;
      r_bit_count  <= '0;
      r_parity_err <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_shreg      <= w_shreg_next;
      r_bit_count  <= w_bit_count_next;
      r_parity_err <= w_parity_err_next;
      // data_out is loaded on the edge that enters DONE so that the new word is already
      // visible during the single data_valid cycle.
      if (w_load_out) begin
        r_data_out <= w_shreg_next;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_next      = r_state;
    w_shreg_next      = r_shreg;
    w_bit_count_next  = r_bit_count;
    w_parity_err_next = r_parity_err;
    w_load_out        = 1'b0;

    unique case (r_state)
      StIdle: begin
        // A bit_valid in the accepting cycle is deliberately ignored.
        if (bus.i_start) begin
          w_state_next      = StRecv;
          w_shreg_next      = '0;
          w_bit_count_next  = '0;
          w_parity_err_next = 1'b0;
        end
      end

      StRecv: begin
        // abort beats a simultaneous bit_valid.
        if (bus.i_abort) begin
          w_state_next     = StIdle;
          w_bit_count_next = '0;
        end else if (bus.i_bit_valid) begin
          // Right shift: first bit received ends up in bit 0 after WIDTH samples.
          w_shreg_next     = {bus.i_serial_in, r_shreg[WIDTH-1:1]};
          w_bit_count_next = r_bit_count + CntW'(1);
          if (r_bit_count == LastIdx) begin
            if (PARITY_EN != 0) begin
              w_state_next = StPar;
            end else begin
              w_state_next = StDone;
              w_load_out   = 1'b1;
            end
          end
        end
      end

      StPar: begin
        if (bus.i_abort) begin
          w_state_next     = StIdle;
          w_bit_count_next = '0;
        end else if (bus.i_bit_valid) begin
          // Even parity: data plus parity bit must contain an even number of ones.
          w_parity_err_next = bus.i_serial_in ^ (^r_shreg);
          w_state_next      = StDone;
          w_load_out        = 1'b1;
        end
      end

      StDone: begin
        // Exactly one cycle; start and abort have no effect here.
        w_state_next = StIdle;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign bus.o_data_out   = r_data_out;
  assign bus.o_data_valid = (r_state == StDone);
  assign bus.o_parity_err = (r_state == StDone) && r_parity_err;
  assign bus.o_busy       = (r_state != StIdle);
  assign bus.o_bit_count  = r_bit_count;

endmodule

// File: tb/tb_shift_receiver.sv
// tb_shift_receiver: directed bench for shift_receiver. Two instances share one clock and
// reset: u_dut0 without parity and u_dut1 with parity. Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point, after the edge has taken effect.
module tb_shift_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] t_start = '0;
  logic [1:0] t_sin   = '0;
  logic [1:0] t_bv    = '0;
  logic [1:0] t_abort = '0;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  shift_receiver_if #(.WIDTH(8)) if0 ();
  shift_receiver_if #(.WIDTH(8)) if1 ();

  assign if0.i_start     = t_start[0];
  assign if0.i_serial_in = t_sin[0];
  assign if0.i_bit_valid = t_bv[0];
  assign if0.i_abort     = t_abort[0];
  assign if1.i_start     = t_start[1];
  assign if1.i_serial_in = t_sin[1];
  assign if1.i_bit_valid = t_bv[1];
  assign if1.i_abort     = t_abort[1];

  shift_receiver #(.WIDTH(8), .PARITY_EN(0)) u_dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (if0)
  );

  shift_receiver #(.WIDTH(8), .PARITY_EN(1)) u_dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (if1)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned get_bc(input int sel);
    return (sel != 0) ? int'(if1.o_bit_count) : int'(if0.o_bit_count);
  endfunction

  function automatic int unsigned get_dv(input int sel);
    return (sel != 0) ? int'(if1.o_data_valid) : int'(if0.o_data_valid);
  endfunction

  function automatic int unsigned get_busy(input int sel);
    return (sel != 0) ? int'(if1.o_busy) : int'(if0.o_busy);
  endfunction

  task automatic do_start(input int sel);
    t_start[sel] = 1'b1;
    tick();
    t_start[sel] = 1'b0;
    check_eq("start_busy", get_busy(sel), 1);
    check_eq("start_bc", get_bc(sel), 0);
  endtask

  // Sends n data bits LSB first. gapped inserts (i % 4) idle cycles after bit i.
  // last_done says whether the final data bit should complete the frame.
  task automatic send_bits(input int sel, input logic [7:0] data, input int n,
                           input bit gapped, input bit hold_start, input bit last_done);
    for (int i = 0; i < n; i++) begin
      t_bv[sel]    = 1'b1;
      t_sin[sel]   = data[i];
      t_start[sel] = hold_start;
      tick();
      t_bv[sel]    = 1'b0;
      t_start[sel] = 1'b0;
      check_eq("bit_bc", get_bc(sel), i + 1);
      check_eq("bit_dv", get_dv(sel), (last_done && i == n - 1) ? 1 : 0);
      if (gapped && i < n - 1) begin
        for (int g = 0; g < i % 4; g++) begin
          tick();
          check_eq("gap_bc", get_bc(sel), i + 1);
          check_eq("gap_dv", get_dv(sel), 0);
        end
      end
    end
  endtask

  initial begin
    // Reset state of both instances.
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_dout0", if0.o_data_out, 0);
    check_eq("rst_dv0", if0.o_data_valid, 0);
    check_eq("rst_busy0", if0.o_busy, 0);
    check_eq("rst_bc0", if0.o_bit_count, 0);
    check_eq("rst_perr1", if1.o_parity_err, 0);
    check_eq("rst_busy1", if1.o_busy, 0);

    // Plain 0xA5 frame, bits 1,0,1,0,0,1,0,1.
    do_start(0);
    send_bits(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check_eq("a5_dout", if0.o_data_out, 8'hA5);
    check_eq("a5_perr", if0.o_parity_err, 0);
    tick();
    check_eq("a5_dv_after", if0.o_data_valid, 0);
    check_eq("a5_busy_after", if0.o_busy, 0);
    check_eq("a5_dout_hold", if0.o_data_out, 8'hA5);

    // Parity instance: good parity then bad parity.
    for (int k = 0; k < 2; k++) begin
      do_start(1);
      send_bits(1, 8'hA5, 8, 1'b0, 1'b0, 1'b0);
      check_eq("par_wait_busy", if1.o_busy, 1);
      tick();
      check_eq("par_idle_dv", if1.o_data_valid, 0);
      t_bv[1]  = 1'b1;
      t_sin[1] = (k != 0);
      tick();
      t_bv[1]  = 1'b0;
      check_eq("par_dv", if1.o_data_valid, 1);
      check_eq("par_err", if1.o_parity_err, k);
      check_eq("par_dout", if1.o_data_out, 8'hA5);
      tick();
      check_eq("par_err_clear", if1.o_parity_err, 0);
      check_eq("par_busy_after", if1.o_busy, 0);
    end

    // Gapped 0x3C frame.
    do_start(0);
    send_bits(0, 8'h3C, 8, 1'b1, 1'b0, 1'b1);
    check_eq("gap_dout", if0.o_data_out, 8'h3C);
    tick();

    // Restore 0xA5, then abort after 4 bits with a bit_valid in the same cycle.
    do_start(0);
    send_bits(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
    tick();
    do_start(0);
    send_bits(0, 8'hFF, 4, 1'b0, 1'b0, 1'b0);
    t_abort[0] = 1'b1;
    t_bv[0]    = 1'b1;
    t_sin[0]   = 1'b1;
    tick();
    t_abort[0] = 1'b0;
    t_bv[0]    = 1'b0;
    check_eq("abort_busy", if0.o_busy, 0);
    check_eq("abort_bc", if0.o_bit_count, 0);
    check_eq("abort_dv", if0.o_data_valid, 0);
    check_eq("abort_dout", if0.o_data_out, 8'hA5);
    do_start(0);
    send_bits(0, 8'h0F, 8, 1'b0, 1'b0, 1'b1);
    check_eq("after_abort_dout", if0.o_data_out, 8'h0F);
    tick();

    // Reset after 5 bits, asserted together with start, bit_valid and abort.
    do_start(0);
    send_bits(0, 8'hFF, 5, 1'b0, 1'b0, 1'b0);
    rst        = 1'b1;
    t_start[0] = 1'b1;
    t_bv[0]    = 1'b1;
    t_abort[0] = 1'b1;
    tick();
    rst        = 1'b0;
    t_start[0] = 1'b0;
    t_bv[0]    = 1'b0;
    t_abort[0] = 1'b0;
    check_eq("mid_rst_dout", if0.o_data_out, 0);
    check_eq("mid_rst_dv", if0.o_data_valid, 0);
    check_eq("mid_rst_busy", if0.o_busy, 0);
    check_eq("mid_rst_bc", if0.o_bit_count, 0);

    // start and bit_valid together in idle: the bit is not counted.
    t_start[0] = 1'b1;
    t_bv[0]    = 1'b1;
    t_sin[0]   = 1'b1;
    tick();
    t_start[0] = 1'b0;
    t_bv[0]    = 1'b0;
    check_eq("sbv_busy", if0.o_busy, 1);
    check_eq("sbv_bc", if0.o_bit_count, 0);

    // start held high on every bit: no restart, frame completes as 0x5A.
    send_bits(0, 8'h5A, 8, 1'b0, 1'b1, 1'b1);
    check_eq("restart_dout", if0.o_data_out, 8'h5A);
    // start during DONE is ignored; one cycle later in idle it is accepted.
    t_start[0] = 1'b1;
    tick();
    check_eq("done_start_busy", if0.o_busy, 0);
    tick();
    t_start[0] = 1'b0;
    check_eq("b2b_busy", if0.o_busy, 1);
    check_eq("b2b_bc", if0.o_bit_count, 0);
    t_abort[0] = 1'b1;
    tick();
    t_abort[0] = 1'b0;
    check_eq("final_busy", if0.o_busy, 0);
    check_eq("final_dout", if0.o_data_out, 8'h5A);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
